// File: rtl/rf_bypass_sb.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports with same-cycle write bypass, and a per-register busy scoreboard
// (set by reserve at decode, cleared by the writeback write).
module rf_bypass_sb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned SELW     = 3,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  read1regsel,
  input  logic [SELW-1:0]  read2regsel,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             read1busy,
  output logic             read2busy,
  input  logic [SELW-1:0]  writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  input  logic             reserve,
  input  logic [SELW-1:0]  reserveregsel,
  output logic             err
);

  // One extra bit so NREGS == 2**SELW still compares correctly.
  localparam logic [SELW:0] NRegsExt = (SELW + 1)'(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q;

  logic             wr_en;
  logic             rv_en;
  logic [SELW-1:0]  rsel  [2];
  logic [WIDTH-1:0] rdata [2];
  logic             rbusy [2];

  function automatic logic legal(input logic [SELW-1:0] s);
    return {1'b0, s} < NRegsExt;
  endfunction

  function automatic logic is_zero(input logic [SELW-1:0] s);
    return (ZERO_REG != 0) && (s == '0);
  endfunction

  assign rsel[0] = read1regsel;
  assign rsel[1] = read2regsel;

  // Qualified write/reserve strobes: dropped on reset, illegal select or hardwired r0.
  always_comb begin
    wr_en = !rst && write && legal(writeregsel) && !is_zero(writeregsel);
    rv_en = !rst && reserve && legal(reserveregsel) && !is_zero(reserveregsel);
  end

  // Illegal-select flag, suppressed while in reset.
  always_comb begin
    err = !rst && (!legal(read1regsel) || !legal(read2regsel) ||
                   (write && !legal(writeregsel)) ||
                   (reserve && !legal(reserveregsel)));
  end

  // Read ports: illegal/zero/reset read 0; a same-cycle write bypasses data and clears busy.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      if (!rst && legal(rsel[p]) && !is_zero(rsel[p])) begin
        if (write && (writeregsel == rsel[p])) begin
          rdata[p] = writedata;
        end else begin
          rdata[p] = regs_q[rsel[p]];
          rbusy[p] = busy_q[rsel[p]];
        end
      end
    end
  end

  assign read1data = rdata[0];
  assign read2data = rdata[1];
  assign read1busy = rbusy[0];
  assign read2busy = rbusy[1];

  // State update; the reserve assignment comes last so it wins over the write's busy clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[writeregsel] <= writedata;
        busy_q[writeregsel] <= 1'b0;
      end
      if (rv_en) begin
        busy_q[reserveregsel] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Bench for rf_bypass_sb: instance 0 is the default 8x16 file, instance 1 is
// 6x32 with hardwired-zero r0. A behavioural model tracks both.
module tb_rf_bypass_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s [2];
  logic        wr    [2];
  logic        rv    [2];
  logic [2:0]  r1    [2];
  logic [2:0]  r2    [2];
  logic [2:0]  ws    [2];
  logic [2:0]  rs    [2];
  logic [31:0] wd    [2];

  logic [15:0] a_d1, a_d2;
  logic [31:0] z_d1, z_d2;
  logic        a_b1, a_b2, a_err, z_b1, z_b2, z_err;

  logic [31:0] o_d1 [2];
  logic [31:0] o_d2 [2];
  logic        o_b1 [2];
  logic        o_b2 [2];
  logic        o_err [2];

  assign o_d1[0] = {16'h0, a_d1};
  assign o_d2[0] = {16'h0, a_d2};
  assign o_d1[1] = z_d1;
  assign o_d2[1] = z_d2;
  assign o_b1[0] = a_b1;
  assign o_b2[0] = a_b2;
  assign o_b1[1] = z_b1;
  assign o_b2[1] = z_b2;
  assign o_err[0] = a_err;
  assign o_err[1] = z_err;

  rf_bypass_sb dut_a (
    .clk(clk), .rst(rst_s[0]),
    .read1regsel(r1[0]), .read2regsel(r2[0]),
    .read1data(a_d1), .read2data(a_d2), .read1busy(a_b1), .read2busy(a_b2),
    .writeregsel(ws[0]), .writedata(wd[0][15:0]), .write(wr[0]),
    .reserve(rv[0]), .reserveregsel(rs[0]), .err(a_err)
  );

  rf_bypass_sb #(.WIDTH(32), .NREGS(6), .SELW(3), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst_s[1]),
    .read1regsel(r1[1]), .read2regsel(r2[1]),
    .read1data(z_d1), .read2data(z_d2), .read1busy(z_b1), .read2busy(z_b2),
    .writeregsel(ws[1]), .writedata(wd[1]), .write(wr[1]),
    .reserve(rv[1]), .reserveregsel(rs[1]), .err(z_err)
  );

  // Reference model state
  logic [31:0] m_regs [2][8];
  bit          m_busy [2][8];

  int checks = 0;
  int failures = 0;

  logic [31:0] e_d1, e_d2;
  logic        e_b1, e_b2, e_err;

  function automatic int nregs_of(input int d);
    return (d == 1) ? 6 : 8;
  endfunction

  function automatic logic [31:0] mask_of(input int d);
    return (d == 1) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic void rd_expect(input int d, input logic [2:0] s,
                                    output logic [31:0] data, output logic b);
    int n = nregs_of(d);
    data = '0;
    b = 1'b0;
    if (rst_s[d] || int'(s) >= n || (d == 1 && s == 0)) return;
    if (wr[d] && ws[d] == s) begin
      data = wd[d] & mask_of(d);
    end else begin
      data = m_regs[d][s];
      b = m_busy[d][s];
    end
  endfunction

  task automatic predict(input int d);
    int n = nregs_of(d);
    e_err = !rst_s[d] && (int'(r1[d]) >= n || int'(r2[d]) >= n ||
                          (wr[d] && int'(ws[d]) >= n) || (rv[d] && int'(rs[d]) >= n));
    rd_expect(d, r1[d], e_d1, e_b1);
    rd_expect(d, r2[d], e_d2, e_b2);
  endtask

  // Clock one edge, update the model for both instances, return at the falling edge.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int n = nregs_of(d);
      if (rst_s[d]) begin
        for (int i = 0; i < 8; i++) begin
          m_regs[d][i] = '0;
          m_busy[d][i] = 0;
        end
      end else begin
        if (wr[d] && int'(ws[d]) < n && !(d == 1 && ws[d] == 0)) begin
          m_regs[d][ws[d]] = wd[d] & mask_of(d);
          m_busy[d][ws[d]] = 0;
        end
        if (rv[d] && int'(rs[d]) < n && !(d == 1 && rs[d] == 0)) m_busy[d][rs[d]] = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    rst_s[d] = 0; wr[d] = 0; rv[d] = 0;
    r1[d] = 0; r2[d] = 0; ws[d] = 0; rs[d] = 0; wd[d] = 0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      idle(d);
      rst_s[d] = 1; wr[d] = 1; ws[d] = 3; wd[d] = $urandom; r1[d] = 3; rv[d] = 1; rs[d] = 7;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_d1[d] !== 0 || o_b1[d] !== 0 || o_err[d] !== 0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got d=%h b=%b err=%b want 0/0/0",
                 d, o_d1[d], o_b1[d], o_err[d]);
      end
    end
    step();
    step();
    for (int d = 0; d < 2; d++) idle(d);
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 2; d++) begin
        r1[d] = 3'(s); r2[d] = 3'(s);
      end
      #2;
      for (int d = 0; d < 2; d++) begin
        if (s < nregs_of(d)) begin
          checks++;
          if (o_d1[d] !== 0 || o_d2[d] !== 0 || o_b1[d] !== 0 || o_b2[d] !== 0 ||
              o_err[d] !== 0) begin
            failures++;
            $display("FAIL reset_read inst=%0d sel=%0d got d=%h/%h b=%b/%b err=%b want 0",
                     d, s, o_d1[d], o_d2[d], o_b1[d], o_b2[d], o_err[d]);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_write_bypass();
    idle(0);
    wr[0] = 1; ws[0] = 3; wd[0] = 32'hBEEF; r1[0] = 3;
    #2;
    checks++;
    if (o_d1[0] !== 32'hBEEF) begin
      failures++;
      $display("FAIL bypass_same_cycle got %h want 0000beef", o_d1[0]);
    end
    step();
    wr[0] = 0;
    #2;
    checks++;
    if (o_d1[0] !== 32'hBEEF || o_b1[0] !== 0) begin
      failures++;
      $display("FAIL write_stored got d=%h b=%b want 0000beef/0", o_d1[0], o_b1[0]);
    end
    step();
  endtask

  task automatic test_scoreboard();
    idle(0);
    rv[0] = 1; rs[0] = 5; r2[0] = 5;
    #2;
    checks++;
    if (o_b2[0] !== 0) begin
      failures++;
      $display("FAIL reserve_not_early got b=%b want 0", o_b2[0]);
    end
    step();
    rv[0] = 0;
    #2;
    checks++;
    if (o_b2[0] !== 1) begin
      failures++;
      $display("FAIL reserve_busy got b=%b want 1", o_b2[0]);
    end
    step();
    wr[0] = 1; ws[0] = 5; wd[0] = 32'h1234;
    #2;
    checks++;
    if (o_b2[0] !== 0 || o_d2[0] !== 32'h1234) begin
      failures++;
      $display("FAIL writeback_bypass got d=%h b=%b want 00001234/0", o_d2[0], o_b2[0]);
    end
    step();
    wr[0] = 0;
    #2;
    checks++;
    if (o_b2[0] !== 0 || o_d2[0] !== 32'h1234) begin
      failures++;
      $display("FAIL writeback_clear got d=%h b=%b want 00001234/0", o_d2[0], o_b2[0]);
    end
    step();
  endtask

  task automatic test_collision();
    idle(0);
    wr[0] = 1; ws[0] = 2; wd[0] = 32'h00AA; rv[0] = 1; rs[0] = 2;
    step();
    idle(0);
    r1[0] = 2;
    #2;
    checks++;
    if (o_d1[0] !== 32'h00AA || o_b1[0] !== 1) begin
      failures++;
      $display("FAIL collision got d=%h b=%b want 000000aa/1", o_d1[0], o_b1[0]);
    end
    step();
  endtask

  task automatic test_zero_illegal();
    idle(1);
    wr[1] = 1; ws[1] = 0; wd[1] = 32'hFFFF_FFFF; rv[1] = 1; rs[1] = 0; r1[1] = 0;
    #2;
    checks++;
    if (o_d1[1] !== 0 || o_b1[1] !== 0 || o_err[1] !== 0) begin
      failures++;
      $display("FAIL zero_no_bypass got d=%h b=%b err=%b want 0/0/0",
               o_d1[1], o_b1[1], o_err[1]);
    end
    step();
    idle(1);
    wr[1] = 1; ws[1] = 3; wd[1] = 32'h1357_9BDF;
    step();
    idle(1);
    #2;
    checks++;
    if (o_d1[1] !== 0 || o_b1[1] !== 0) begin
      failures++;
      $display("FAIL zero_after got d=%h b=%b want 0/0", o_d1[1], o_b1[1]);
    end
    wr[1] = 1; ws[1] = 7; wd[1] = 32'hDEAD_BEEF; rv[1] = 1; rs[1] = 6;
    #2;
    checks++;
    if (o_err[1] !== 1) begin
      failures++;
      $display("FAIL illegal_write_err got %b want 1", o_err[1]);
    end
    step();
    idle(1);
    for (int s = 0; s < 6; s++) begin
      r1[1] = 3'(s);
      #1;
      checks++;
      if (o_d1[1] !== ((s == 3) ? 32'h1357_9BDF : 32'h0) || o_b1[1] !== 0) begin
        failures++;
        $display("FAIL illegal_no_change sel=%0d got d=%h b=%b", s, o_d1[1], o_b1[1]);
      end
    end
    step();
    r1[1] = 6;
    #2;
    checks++;
    if (o_err[1] !== 1 || o_d1[1] !== 0 || o_b1[1] !== 0) begin
      failures++;
      $display("FAIL illegal_read got err=%b d=%h b=%b want 1/0/0",
               o_err[1], o_d1[1], o_b1[1]);
    end
    step();
    idle(1);
  endtask

  task automatic test_reset_mid();
    idle(0);
    rv[0] = 1; rs[0] = 1;
    step();
    rs[0] = 4; wr[0] = 1; ws[0] = 4; wd[0] = 32'h5555;
    step();
    rst_s[0] = 1; wr[0] = 1; ws[0] = 4; wd[0] = 32'hFFFF; rv[0] = 1; rs[0] = 6; r1[0] = 4;
    #2;
    checks++;
    if (o_d1[0] !== 0 || o_err[0] !== 0) begin
      failures++;
      $display("FAIL reset_mid_during got d=%h err=%b want 0/0", o_d1[0], o_err[0]);
    end
    step();
    idle(0);
    for (int s = 0; s < 8; s++) begin
      r1[0] = 3'(s);
      #1;
      checks++;
      if (o_d1[0] !== 0 || o_b1[0] !== 0) begin
        failures++;
        $display("FAIL reset_mid_after sel=%0d got d=%h b=%b want 0/0", s, o_d1[0], o_b1[0]);
      end
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst_s[d] = ($urandom_range(49, 0) == 0);
        wr[d] = $urandom_range(1, 0) == 1;
        rv[d] = $urandom_range(2, 0) == 0;
        r1[d] = 3'($urandom_range(7, 0));
        r2[d] = ($urandom_range(3, 0) == 0) ? r1[d] : 3'($urandom_range(7, 0));
        ws[d] = ($urandom_range(2, 0) == 0) ? r1[d] : 3'($urandom_range(7, 0));
        rs[d] = ($urandom_range(3, 0) == 0) ? ws[d] : 3'($urandom_range(7, 0));
        wd[d] = $urandom;
      end
      #2;
      for (int d = 0; d < 2; d++) begin
        predict(d);
        checks++;
        if (o_d1[d] !== e_d1 || o_d2[d] !== e_d2 || o_b1[d] !== e_b1 ||
            o_b2[d] !== e_b2 || o_err[d] !== e_err) begin
          failures++;
          $display("FAIL random inst=%0d cyc=%0d got d=%h/%h b=%b/%b err=%b want %h/%h %b/%b %b",
                   d, c, o_d1[d], o_d2[d], o_b1[d], o_b2[d], o_err[d],
                   e_d1, e_d2, e_b1, e_b2, e_err);
        end
      end
      step();
    end
    for (int d = 0; d < 2; d++) idle(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle(d);
      for (int i = 0; i < 8; i++) begin
        m_regs[d][i] = '0;
        m_busy[d][i] = 0;
      end
    end
    @(negedge clk);
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_collision();
    test_zero_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_bypass_sb.md
Name: rf_bypass_sb

Overview:
- Parametrised successor to the fixed 8x16 bypassing register file.
- Configurable width and register count; optional hardwired-zero register 0.
- Two combinational read ports with write-to-read bypass; one synchronous write port.
- Per-register busy scoreboard, reserved at decode and cleared at writeback, so the pipelined CPU can detect RAW hazards.

Parameters:
WIDTH, 16, data width in bits
NREGS, 8, number of architectural registers, 2..2^SELW
SELW, 3, register-select width
ZERO_REG, 0, 1 = register 0 always reads 0; writes and reserves to it are ignored

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
read1regsel  input  SELW  read port 1 register select
read2regsel  input  SELW  read port 2 register select
read1data  output  WIDTH  read port 1 data (combinational)
read2data  output  WIDTH  read port 2 data (combinational)
read1busy  output  1  selected register 1 has an outstanding reservation
read2busy  output  1  selected register 2 has an outstanding reservation
writeregsel  input  SELW  write register select
writedata  input  WIDTH  write data
write  input  1  write enable
reserve  input  1  reserve request (sets busy)
reserveregsel  input  SELW  register to reserve
err  output  1  illegal select (combinational)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- State:
  - regs[NREGS] of WIDTH bits.
  - busy[NREGS] of 1 bit.
- Reset:
  - rst sampled high at a rising edge clears all regs and busy to 0.
  - While rst is high: read1data/read2data = 0, read1busy/read2busy = 0, err = 0, write and reserve are ignored.
- Write:
  - At a rising edge with write=1 and rst=0: regs[writeregsel] <= writedata and busy[writeregsel] <= 0.
  - The reserve rule below overrides the busy clear.
- Reserve:
  - At a rising edge with reserve=1 and rst=0: busy[reserveregsel] <= 1.
  - If write and reserve target the same register in the same cycle, the data is written and busy ends at 1. Reserve wins, because a new producer has been issued.
- Read data (port n = 1, 2):
  - If write=1, writeregsel==readnregsel and the register is legal: readndata = writedata (bypass, same cycle).
  - Otherwise readndata = regs[readnregsel].
- Read busy:
  - readnbusy = busy[readnregsel], except it is 0 when a bypassing write to that register occurs this cycle.
  - A same-cycle reserve does not affect readnbusy until the next cycle.
- ZERO_REG=1:
  - Select 0 reads data 0 and busy 0, and is never bypassed.
  - Writes and reserves to register 0 have no effect.
- Illegal select (any sel >= NREGS):
  - err=1 if read1regsel or read2regsel >= NREGS, or write=1 with writeregsel >= NREGS, or reserve=1 with reserveregsel >= NREGS.
  - The offending write/reserve is dropped: no state change.
  - An illegal read returns data 0 and busy 0.
- Both read ports may select the same register; they return identical values.
- Reserving an already-busy register leaves it busy, with no error.
- Writing a non-busy register is legal.
- No internal latency beyond one edge for state; reads are zero-latency.

Test Plan:
1. Reset then read all regs: rst=1 for 2 cycles, then read sel 0..7 -> every read returns 0x0000, busy 0, err 0.
2. Write/read and bypass: write r3=0xBEEF and hold; read1regsel=3 in the same cycle -> read1data=0xBEEF before the edge; after the edge, with write=0 -> still 0xBEEF.
3. Scoreboard: reserve r5 at edge 1 -> read2busy(r5)=1 from cycle 2. Write r5=0x1234 in cycle 4 -> in cycle 4, read2busy=0 and read2data=0x1234 via bypass; busy[5]=0 after the edge.
4. Collision: in one cycle, write r2=0x00AA and reserve r2 -> after the edge, r2 reads 0x00AA with busy=1.
5. ZERO_REG=1, NREGS=6, WIDTH=32: write r0=0xFFFFFFFF and reserve r0 -> r0 reads 0, busy 0. write=1, writeregsel=7 -> err=1 and no register changes. read1regsel=6 -> err=1 and read1data=0.
6. Reset mid-operation: reserve r1 and r4 and write r4=0x5555, then assert rst with write=1 in the same cycle -> after the edge, all busy=0 and all regs=0; the concurrent write is discarded.
